// File: rtl/matrix_mac_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// matrix_mac_pkg
//   Shared definitions for the matrix MAC sequencer slice: the sequencer state
//   encoding, default dimension/address widths and the width of the optional
//   performance counters.
//   No ports (package).
// -----------------------------------------------------------------------------
package matrix_mac_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int DIM_WIDTH_DEF  = 4;
   localparam int ADDR_WIDTH_DEF = 8;
   localparam int PERF_WIDTH     = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_MAC   = 3'd2,
      S_DRAIN = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } seq_state_e;

endpackage

// File: rtl/matrix_mac_sequencer_if.sv
// -----------------------------------------------------------------------------
// matrix_mac_sequencer_if
//   Bundles the sequencer's host, operand-read, MAC-control and result-write
//   signals.
//   Host side     : start, cfg_m, cfg_n, cfg_k -> sequencer; busy, done, err <-
//   Operand reads : rd_en, a_addr, b_addr (read data returns the next cycle)
//   MAC control   : mac_enable, mac_clear
//   Result write  : wr_en, wr_addr -> sink; wr_ready <- sink
//   Modports: master = sequencer, slave = surrounding system.
//
//   Write handshake: wr_en is a valid. Once raised, wr_en and wr_addr stay
//   constant until a cycle in which wr_ready is also high; that cycle is the
//   transfer. wr_ready may stay low indefinitely.
// -----------------------------------------------------------------------------
interface matrix_mac_sequencer_if
   import matrix_mac_pkg::*;
#(
   parameter int DIM_WIDTH  = DIM_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
   logic                  start;
   logic [DIM_WIDTH-1:0]  cfg_m;
   logic [DIM_WIDTH-1:0]  cfg_n;
   logic [DIM_WIDTH-1:0]  cfg_k;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] a_addr;
   logic [ADDR_WIDTH-1:0] b_addr;
   logic                  mac_enable;
   logic                  mac_clear;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  wr_ready;

   modport master (
      input  start, cfg_m, cfg_n, cfg_k, wr_ready,
      output busy, done, err, rd_en, a_addr, b_addr,
             mac_enable, mac_clear, wr_en, wr_addr
   );

   modport slave (
      output start, cfg_m, cfg_n, cfg_k, wr_ready,
      input  busy, done, err, rd_en, a_addr, b_addr,
             mac_enable, mac_clear, wr_en, wr_addr
   );
endinterface

// File: rtl/matrix_mac_sequencer_addr_gen.sv
// -----------------------------------------------------------------------------
// matrix_mac_addr_gen
//   Owns the i/j/k loop counters and produces the operand and result
//   addresses purely with adders:
//     a_addr  = i*K + k   (row base advances by K per row, +1 per k)
//     b_addr  = k*N + j   (starts at j, advances by N per k)
//     wr_addr = i*N + j   (+1 per finished element)
//   All address arithmetic wraps modulo 2^ADDR_WIDTH.
//   Ports:
//     clk_i, rst_ni            clock, async active-low reset
//     init_i                   restart all counters at element (0,0)
//     step_k_i                 advance k within the current element
//     step_elem_i              move to the next output element
//     dim_m_i/dim_n_i/dim_k_i  latched job dimensions (all non-zero when used)
//     a_addr_o/b_addr_o        operand addresses for the current k
//     wr_addr_o                result address of the current element
//     last_k_o                 current k is K-1
//     last_elem_o              current element is (M-1, N-1)
// -----------------------------------------------------------------------------
module matrix_mac_addr_gen
   import matrix_mac_pkg::*;
#(
   parameter int DIM_WIDTH  = DIM_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  init_i,
   input  logic                  step_k_i,
   input  logic                  step_elem_i,
   input  logic [DIM_WIDTH-1:0]  dim_m_i,
   input  logic [DIM_WIDTH-1:0]  dim_n_i,
   input  logic [DIM_WIDTH-1:0]  dim_k_i,
   output logic [ADDR_WIDTH-1:0] a_addr_o,
   output logic [ADDR_WIDTH-1:0] b_addr_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic                  last_k_o,
   output logic                  last_elem_o
);

   logic [DIM_WIDTH-1:0]  i_q, j_q, k_q;
   logic [ADDR_WIDTH-1:0] a_base_q, a_addr_q, b_addr_q, wr_addr_q;

   logic                  last_i, last_j;
   logic [ADDR_WIDTH-1:0] n_ext, k_ext, j_next_ext;

   assign n_ext      = ADDR_WIDTH'(dim_n_i);
   assign k_ext      = ADDR_WIDTH'(dim_k_i);
   assign j_next_ext = ADDR_WIDTH'(j_q + DIM_WIDTH'(1));

   assign last_i      = (i_q == dim_m_i - DIM_WIDTH'(1));
   assign last_j      = (j_q == dim_n_i - DIM_WIDTH'(1));
   assign last_k_o    = (k_q == dim_k_i - DIM_WIDTH'(1));
   assign last_elem_o = last_i && last_j;

   assign a_addr_o  = a_addr_q;
   assign b_addr_o  = b_addr_q;
   assign wr_addr_o = wr_addr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         i_q       <= '0;
         j_q       <= '0;
         k_q       <= '0;
         a_base_q  <= '0;
         a_addr_q  <= '0;
         b_addr_q  <= '0;
         wr_addr_q <= '0;
      end else if (init_i) begin
         i_q       <= '0;
         j_q       <= '0;
         k_q       <= '0;
         a_base_q  <= '0;
         a_addr_q  <= '0;
         b_addr_q  <= '0;
         wr_addr_q <= '0;
      end else if (step_k_i) begin
         // a/b run past the element end here; step_elem reloads them.
         k_q      <= last_k_o ? '0 : k_q + DIM_WIDTH'(1);
         a_addr_q <= a_addr_q + ADDR_WIDTH'(1);
         b_addr_q <= b_addr_q + n_ext;
      end else if (step_elem_i) begin
         k_q       <= '0;
         wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
         if (last_j) begin
            // Next row: A row base moves by K, B restarts at column 0.
            j_q      <= '0;
            i_q      <= i_q + DIM_WIDTH'(1);
            a_base_q <= a_base_q + k_ext;
            a_addr_q <= a_base_q + k_ext;
            b_addr_q <= '0;
         end else begin
            j_q      <= j_q + DIM_WIDTH'(1);
            a_addr_q <= a_base_q;
            b_addr_q <= j_next_ext;
         end
      end
   end

endmodule

// File: rtl/matrix_mac_sequencer.sv
// -----------------------------------------------------------------------------
// matrix_mac_sequencer
//   Drives one MAC unit to compute C = A x B (A is MxK, B is KxN, both
//   row-major). For each output element: one clear cycle, K operand reads,
//   a drain of MAC_LATENCY+1 cycles, then a handshaked result write.
//   Ports:
//     clock, reset      clock, asynchronous active-low reset
//     bus (master)      start/cfg/busy/done/err, rd_en/a_addr/b_addr,
//                       mac_enable/mac_clear, wr_en/wr_addr/wr_ready
//     dbg_state_o       current sequencer state (matrix_mac_pkg encoding)
//   Optional feature (define MATRIX_MAC_SEQ_PERF_EN):
//     perf_cycles       busy cycles of the last/current job, saturating
//     perf_stalls       WRITE cycles with wr_ready low, saturating
// -----------------------------------------------------------------------------
module matrix_mac_sequencer
   import matrix_mac_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int DIM_WIDTH   = DIM_WIDTH_DEF,
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int MAC_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   matrix_mac_sequencer_if.master bus,
   output logic [2:0]            dbg_state_o
`ifdef MATRIX_MAC_SEQ_PERF_EN
   ,
   output logic [PERF_WIDTH-1:0] perf_cycles,
   output logic [PERF_WIDTH-1:0] perf_stalls
`endif
);

   localparam logic [2:0] ST_IDLE  = S_IDLE;
   localparam logic [2:0] ST_CLEAR = S_CLEAR;
   localparam logic [2:0] ST_MAC   = S_MAC;
   localparam logic [2:0] ST_DRAIN = S_DRAIN;
   localparam logic [2:0] ST_WRITE = S_WRITE;
   localparam logic [2:0] ST_DONE  = S_DONE;

   // Drain covers MAC_LATENCY plus the one-cycle read-data delay.
   localparam int                  DRAIN_W    = $clog2(MAC_LATENCY + 2);
   localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(MAC_LATENCY);

   // The operand width only matters to the MAC unit this block drives.
   if (DATA_WIDTH < 1) begin : g_bad_data_width
      $error("matrix_mac_sequencer: DATA_WIDTH must be at least 1");
   end

   logic [2:0]           state_q, state_d;
   logic [DIM_WIDTH-1:0] cfg_m_q, cfg_m_d;
   logic [DIM_WIDTH-1:0] cfg_n_q, cfg_n_d;
   logic [DIM_WIDTH-1:0] cfg_k_q, cfg_k_d;
   logic                 err_q, err_d;
   logic [DRAIN_W-1:0]   drain_q, drain_d;
   logic                 mac_enable_q;

   logic ag_init, ag_step_k, ag_step_elem;
   logic ag_last_k, ag_last_elem;
   logic accept, zero_dim;

   assign accept   = (state_q == ST_IDLE) && bus.start;
   assign zero_dim = (bus.cfg_m == '0) || (bus.cfg_n == '0) || (bus.cfg_k == '0);

   always_comb begin
      state_d      = state_q;
      cfg_m_d      = cfg_m_q;
      cfg_n_d      = cfg_n_q;
      cfg_k_d      = cfg_k_q;
      err_d        = err_q;
      drain_d      = '0;
      ag_init      = 1'b0;
      ag_step_k    = 1'b0;
      ag_step_elem = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               cfg_m_d = bus.cfg_m;
               cfg_n_d = bus.cfg_n;
               cfg_k_d = bus.cfg_k;
               ag_init = 1'b1;
               err_d   = zero_dim;
               state_d = zero_dim ? ST_DONE : ST_CLEAR;
            end
         end
         ST_CLEAR: state_d = ST_MAC;
         ST_MAC: begin
            ag_step_k = 1'b1;
            if (ag_last_k) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (drain_q == DRAIN_LAST) state_d = ST_WRITE;
            else                       drain_d = drain_q + DRAIN_W'(1);
         end
         ST_WRITE: begin
            if (bus.wr_ready) begin
               ag_step_elem = 1'b1;
               state_d      = ag_last_elem ? ST_DONE : ST_CLEAR;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cfg_m_q      <= '0;
         cfg_n_q      <= '0;
         cfg_k_q      <= '0;
         err_q        <= 1'b0;
         drain_q      <= '0;
         mac_enable_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cfg_m_q      <= cfg_m_d;
         cfg_n_q      <= cfg_n_d;
         cfg_k_q      <= cfg_k_d;
         err_q        <= err_d;
         drain_q      <= drain_d;
         // Read data returns one cycle after rd_en; enable tracks it.
         mac_enable_q <= (state_q == ST_MAC);
      end
   end

   matrix_mac_addr_gen #(
      .DIM_WIDTH  (DIM_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .clk_i       (clock),
      .rst_ni      (reset),
      .init_i      (ag_init),
      .step_k_i    (ag_step_k),
      .step_elem_i (ag_step_elem),
      .dim_m_i     (cfg_m_q),
      .dim_n_i     (cfg_n_q),
      .dim_k_i     (cfg_k_q),
      .a_addr_o    (bus.a_addr),
      .b_addr_o    (bus.b_addr),
      .wr_addr_o   (bus.wr_addr),
      .last_k_o    (ag_last_k),
      .last_elem_o (ag_last_elem)
   );

   assign bus.rd_en      = (state_q == ST_MAC);
   assign bus.mac_clear  = (state_q == ST_CLEAR);
   assign bus.mac_enable = mac_enable_q;
   assign bus.wr_en      = (state_q == ST_WRITE);
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.done       = (state_q == ST_DONE);
   assign bus.err        = err_q;
   assign dbg_state_o    = state_q;

`ifdef MATRIX_MAC_SEQ_PERF_EN
   logic [PERF_WIDTH-1:0] perf_cycles_q, perf_stalls_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_cycles_q <= '0;
         perf_stalls_q <= '0;
      end else if (accept) begin
         perf_cycles_q <= '0;
         perf_stalls_q <= '0;
      end else begin
         if ((state_q != ST_IDLE) && (perf_cycles_q != '1))
            perf_cycles_q <= perf_cycles_q + PERF_WIDTH'(1);
         if ((state_q == ST_WRITE) && !bus.wr_ready && (perf_stalls_q != '1))
            perf_stalls_q <= perf_stalls_q + PERF_WIDTH'(1);
      end
   end

   assign perf_cycles = perf_cycles_q;
   assign perf_stalls = perf_stalls_q;
`else
   // accept only feeds the performance counters.
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matrix_mac_sequencer
//   Directed bench for matrix_mac_sequencer. The environment holds operand
//   memories with a one-cycle read and a behavioural MAC accumulator. The
//   expected read-address stream and result stream come from a plain triple
//   loop over (i, j, k); a monitor compares every rd_en and every write
//   handshake against them. Observes MATRIX_MAC_SEQ_PERF_EN when defined.
// -----------------------------------------------------------------------------
module tb_matrix_mac_sequencer;
   import matrix_mac_pkg::*;

   localparam int DW = 4;
   localparam int AW = 8;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   matrix_mac_sequencer_if #(.DIM_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
   logic [2:0] dbg_state;
`ifdef MATRIX_MAC_SEQ_PERF_EN
   logic [15:0] perf_cycles, perf_stalls;
`endif

   matrix_mac_sequencer #(
      .DATA_WIDTH  (8),
      .DIM_WIDTH   (DW),
      .ADDR_WIDTH  (AW),
      .MAC_LATENCY (1)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus),
      .dbg_state_o (dbg_state)
`ifdef MATRIX_MAC_SEQ_PERF_EN
      ,
      .perf_cycles (perf_cycles),
      .perf_stalls (perf_stalls)
`endif
   );

   // ---------------- environment: memories + MAC ----------------
   logic [7:0]  mem_a [256];
   logic [7:0]  mem_b [256];
   logic [7:0]  rd_a = '0, rd_b = '0;
   logic [31:0] acc = '0;

   always @(posedge clock) begin
      if (bus.rd_en) begin
         rd_a <= mem_a[bus.a_addr];
         rd_b <= mem_b[bus.b_addr];
      end
      if (bus.mac_clear)       acc <= '0;
      else if (bus.mac_enable) acc <= acc + 32'(rd_a) * 32'(rd_b);
   end

   // ---------------- scoreboard ----------------
   logic [15:0] exp_rd_q [$];   // {a_addr, b_addr}
   logic [39:0] exp_wr_q [$];   // {wr_addr, result}

   int n_cmp = 0;
   int n_fail = 0;

   int n_rd, n_en, n_clear, n_wr_cyc, n_hs, first_rd_cyc, first_en_cyc;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_addr = '0;
   int         accept_cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_stats();
      n_rd = 0; n_en = 0; n_clear = 0; n_wr_cyc = 0; n_hs = 0;
      first_rd_cyc = -1; first_en_cyc = -1;
      prev_stall = 1'b0;
      exp_rd_q.delete();
      exp_wr_q.delete();
   endtask

   task automatic fill_mem();
      for (int x = 0; x < 256; x++) begin
         mem_a[x] = 8'(x * 3 + 1);
         mem_b[x] = 8'(x * 7 + 2);
      end
   endtask

   // Model: C[i][j] = sum_k A[i*K+k] * B[k*N+j], visited row by row.
   task automatic build_expect(input int m, input int n, input int k);
      for (int i = 0; i < m; i++)
         for (int j = 0; j < n; j++) begin
            longint sum = 0;
            for (int kk = 0; kk < k; kk++) begin
               int a = (i * k + kk) % 256;
               int b = (kk * n + j) % 256;
               exp_rd_q.push_back({8'(a), 8'(b)});
               sum += longint'(mem_a[a]) * longint'(mem_b[b]);
            end
            exp_wr_q.push_back({8'((i * n + j) % 256), 32'(sum)});
         end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clock) begin
      if (reset) begin
         if (bus.rd_en) begin
            if (n_rd == 0) first_rd_cyc = cyc;
            n_rd++;
            check("rd_expected", 64'(exp_rd_q.size() != 0), 1);
            if (exp_rd_q.size() != 0)
               check("rd_addr", {bus.a_addr, bus.b_addr}, exp_rd_q.pop_front());
         end
         if (bus.mac_enable) begin
            if (n_en == 0) first_en_cyc = cyc;
            n_en++;
         end
         if (bus.mac_clear) n_clear++;
         if (bus.wr_en) begin
            n_wr_cyc++;
            check("no_clear_in_write", bus.mac_clear, 0);
            if (prev_stall) check("wr_addr_hold", bus.wr_addr, prev_addr);
            if (bus.wr_ready) begin
               n_hs++;
               check("wr_expected", 64'(exp_wr_q.size() != 0), 1);
               if (exp_wr_q.size() != 0)
                  check("wr_addr_data", {bus.wr_addr, acc}, exp_wr_q.pop_front());
            end
            prev_stall = !bus.wr_ready;
            prev_addr  = bus.wr_addr;
         end else begin
            if (prev_stall) check("wr_en_held", bus.wr_en, 1);
            prev_stall = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_job(input int m, input int n, input int k);
      @(posedge clock); #1;
      bus.cfg_m = DW'(m);
      bus.cfg_n = DW'(n);
      bus.cfg_k = DW'(k);
      bus.start = 1'b1;
      @(posedge clock); #1;
      accept_cyc = cyc;
      bus.start = 1'b0;
      // Scrambled cfg while busy must have no effect.
      bus.cfg_m = '0;
      bus.cfg_n = '0;
      bus.cfg_k = '0;
   endtask

   // lat = index of the done cycle, counting the cycle after the accepting edge as 1.
   task automatic wait_done(input string tag, output int lat);
      lat = -1;
      for (int t = 0; t < 3000; t++) begin
         @(negedge clock);
         if (bus.done) begin
            lat = cyc - accept_cyc + 1;
            break;
         end
      end
      check({tag, "_done_seen"}, 64'(lat >= 0), 1);
      if (lat >= 0) begin
         check({tag, "_busy_at_done"}, bus.busy, 1);
         @(negedge clock);
         check({tag, "_idle_after_done"}, {bus.busy, bus.done}, 0);
      end
   endtask

   task automatic end_job(input string tag, input int hs_exp);
      check({tag, "_rd_left"}, 64'(exp_rd_q.size()), 0);
      check({tag, "_wr_left"}, 64'(exp_wr_q.size()), 0);
      check({tag, "_writes"}, 64'(n_hs), 64'(hs_exp));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_outputs"},
            {bus.rd_en, bus.a_addr, bus.b_addr, bus.mac_enable, bus.mac_clear,
             bus.wr_en, bus.wr_addr, bus.busy, bus.done, bus.err, dbg_state}, 0);
`ifdef MATRIX_MAC_SEQ_PERF_EN
      check({tag, "_perf"}, {perf_cycles, perf_stalls}, 0);
`endif
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #600000;
      $display("FAIL global_timeout: simulation did not finish by t=%0t", $time);
      $fatal(1, "timeout");
   end

   // ---------------- main sequence ----------------
   initial begin
      int lat;
      int found;
      bus.start    = 1'b0;
      bus.cfg_m    = '0;
      bus.cfg_n    = '0;
      bus.cfg_k    = '0;
      bus.wr_ready = 1'b1;
      clear_stats();
      fill_mem();

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check_all_zero("reset");
      @(negedge clock);
      reset = 1'b1;

      // 2x2x2: A=[1,2;3,4], B=[5,6;7,8] -> C=[19,22;43,50]
      clear_stats();
      for (int x = 0; x < 4; x++) begin
         mem_a[x] = 8'(x + 1);
         mem_b[x] = 8'(x + 5);
      end
      build_expect(2, 2, 2);
      check("model_c00", exp_wr_q[0], {8'd0, 32'd19});
      check("model_c01", exp_wr_q[1], {8'd1, 32'd22});
      check("model_c10", exp_wr_q[2], {8'd2, 32'd43});
      check("model_c11", exp_wr_q[3], {8'd3, 32'd50});
      start_job(2, 2, 2);
      wait_done("mm2", lat);
      check("mm2_done_latency", 64'(lat), 25);
      check("mm2_err", bus.err, 0);
      end_job("mm2", 4);
`ifdef MATRIX_MAC_SEQ_PERF_EN
      check("mm2_perf_cycles", perf_cycles, 25);
      check("mm2_perf_stalls", perf_stalls, 0);
`endif

      // 1x1x3: addresses 0,1,2 on both buffers; 3 enables one cycle behind rd_en
      fill_mem();
      clear_stats();
      build_expect(1, 1, 3);
      check("model_rd0", exp_rd_q[0], {8'd0, 8'd0});
      check("model_rd1", exp_rd_q[1], {8'd1, 8'd1});
      check("model_rd2", exp_rd_q[2], {8'd2, 8'd2});
      start_job(1, 1, 3);
      wait_done("k3", lat);
      check("k3_done_latency", 64'(lat), 8);
      check("k3_rd_count", 64'(n_rd), 3);
      check("k3_en_count", 64'(n_en), 3);
      check("k3_en_offset", 64'(first_en_cyc - first_rd_cyc), 1);
      check("k3_clear_count", 64'(n_clear), 1);
      end_job("k3", 1);

      // cfg_k=0: err, done right after the accepting edge (two edges after start
      // was launched), no reads, no writes
      clear_stats();
      start_job(2, 2, 0);
      wait_done("zero", lat);
      check("zero_done_latency", 64'(lat), 1);
      check("zero_err", bus.err, 1);
      check("zero_rd_count", 64'(n_rd), 0);
      check("zero_wr_cycles", 64'(n_wr_cyc), 0);

      // wr_ready low for 5 cycles on the first write
      fill_mem();
      clear_stats();
      build_expect(2, 2, 2);
      bus.wr_ready = 1'b0;
      start_job(2, 2, 2);
      check("stall_err_cleared", bus.err, 0);
      fork
         wait_done("stall", lat);
         begin
            found = 0;
            for (int t = 0; t < 200; t++) begin
               @(posedge clock); #1;
               if (bus.wr_en) begin
                  found = 1;
                  break;
               end
            end
            check("stall_first_write_seen", 64'(found), 1);
            repeat (5) @(posedge clock);
            #1 bus.wr_ready = 1'b1;
         end
      join
      bus.wr_ready = 1'b1;
      check("stall_done_latency", 64'(lat), 30);
      check("stall_wr_cycles", 64'(n_wr_cyc), 9);
      check("stall_clear_count", 64'(n_clear), 4);
      end_job("stall", 4);
`ifdef MATRIX_MAC_SEQ_PERF_EN
      check("stall_perf_stalls", perf_stalls, 5);
      check("stall_perf_cycles", perf_cycles, 30);
`endif

      // Reset while element 1 is in its MAC phase
      fill_mem();
      clear_stats();
      build_expect(2, 2, 2);
      start_job(2, 2, 2);
      found = 0;
      for (int t = 0; t < 200; t++) begin
         @(posedge clock); #1;
         if (n_hs >= 1 && bus.rd_en) begin
            found = 1;
            break;
         end
      end
      check("rst_reached_elem1_mac", 64'(found), 1);
      #2 reset = 1'b0;
      #1 check_all_zero("async_rst");
      exp_rd_q.delete();
      exp_wr_q.delete();
      repeat (2) @(negedge clock);
      check_all_zero("rst_held");
      reset = 1'b1;
      clear_stats();
      mem_a[0] = 8'd9;
      mem_b[0] = 8'd7;
      build_expect(1, 1, 1);
      check("model_single", exp_wr_q[0], {8'd0, 32'd63});
      start_job(1, 1, 1);
      wait_done("after_rst", lat);
      check("after_rst_done_latency", 64'(lat), 6);
      check("after_rst_wr_cycles", 64'(n_wr_cyc), 1);
      end_job("after_rst", 1);

      // start pulsed mid-job with other cfg: ignored
      fill_mem();
      clear_stats();
      build_expect(2, 3, 2);
      start_job(2, 3, 2);
      fork
         wait_done("busy_start", lat);
         begin
            repeat (10) @(posedge clock);
            #1;
            bus.cfg_m = 4'd1;
            bus.cfg_n = 4'd1;
            bus.cfg_k = 4'd1;
            bus.start = 1'b1;
            @(posedge clock);
            #1 bus.start = 1'b0;
         end
      join
      check("busy_start_done_latency", 64'(lat), 37);
      check("busy_start_rd_count", 64'(n_rd), 12);
      end_job("busy_start", 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
